// File: rtl/uart_frame_queue_if.sv
// Push and transmit handshake bundle for uart_frame_queue.
//   master : the surrounding system (word source plus UART TX shifter)
//   slave  : the frame queue itself
// Signals:
//   in_data/in_valid/in_ready   word push, valid/ready
//   tx_start/uart_packet        frame offered to the shifter, held until tx_done
//   tx_done                     one-cycle pulse from the shifter, frame finished
interface uart_frame_queue_if #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned FRAME_W = 11
);
    logic [DATA_W-1:0]  in_data;
    logic               in_valid;
    logic               in_ready;
    logic               tx_start;
    logic               tx_done;
    logic [FRAME_W-1:0] uart_packet;

    modport master (
        output in_data, in_valid, tx_done,
        input  in_ready, tx_start, uart_packet
    );

    modport slave (
        input  in_data, in_valid, tx_done,
        output in_ready, tx_start, uart_packet
    );
endinterface

// File: rtl/uart_frame_queue.sv
// UART frame queue: buffers pushed data words in a DEPTH-entry FIFO, frames each word as
// start + data (LSB first) + optional parity + stop bits, and hands frames one at a time to
// the TX shifter via a tx_start/tx_done handshake.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   bus (slave)    in_data/in_valid/in_ready push; tx_start/uart_packet/tx_done to the shifter
//   parity_odd     0 even / 1 odd parity, sampled when a frame is loaded
//   clr_overflow   synchronous clear of the sticky overflow flag
//   fifo_level     words queued, not counting the frame in flight
//   overflow       sticky: a push was attempted while full
//   frames_sent    wrapping count of completed frames
module uart_frame_queue #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned PARITY_EN = 1,
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned CNT_W     = 16,
    localparam int unsigned FRAME_W  = 1 + DATA_W + PARITY_EN + STOP_BITS,
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_frame_queue_if.slave    bus,
    input  logic                 parity_odd,
    input  logic                 clr_overflow,
    output logic [AW:0]          fifo_level,
    output logic                 overflow,
    output logic [CNT_W-1:0]     frames_sent
);

    typedef enum logic {StIdle, StSend} state_e;

    state_e             stateQ, stateD;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [AW-1:0]      wrPtrQ, rdPtrQ;
    logic [AW:0]        countQ;
    logic [FRAME_W-1:0] packetQ, frameD;
    logic               overflowQ;
    logic [CNT_W-1:0]   framesQ;

    logic full, empty, push, pop, loadFrame, frameDone;

    assign full  = (countQ == (AW+1)'(DEPTH));
    assign empty = (countQ == '0);
    // A pop in the same cycle does not free a slot for a push into a full FIFO.
    assign push  = bus.in_valid && !full;
    assign pop   = loadFrame;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stateQ <= StIdle;
        else        stateQ <= stateD;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle: if (!empty)     stateD = StSend;
            StSend: if (bus.tx_done) stateD = StIdle;
            default:                stateD = StIdle;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // tx_start is decoded from the state register so an async reset drops it immediately.
    always_comb begin
        bus.tx_start = (stateQ == StSend);
        loadFrame    = (stateQ == StIdle) && !empty;
        frameDone    = (stateQ == StSend) && bus.tx_done;
    end

    // ---------------- Frame builder ----------------
    always_comb begin
        frameD              = '1;
        frameD[0]           = 1'b0;
        frameD[DATA_W:1]    = mem[rdPtrQ];
        if (PARITY_EN != 0) frameD[DATA_W+1] = (^mem[rdPtrQ]) ^ parity_odd;
    end

    // ---------------- FIFO ----------------
    always_ff @(posedge clk) begin
        if (push) mem[wrPtrQ] <= bus.in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
            countQ <= '0;
        end else begin
            if (push) wrPtrQ <= wrPtrQ + 1'b1;
            if (pop)  rdPtrQ <= rdPtrQ + 1'b1;
            if (push && !pop)      countQ <= countQ + 1'b1;
            else if (!push && pop) countQ <= countQ - 1'b1;
        end
    end

    // ---------------- Packet, overflow, counter ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            packetQ   <= '1;
            overflowQ <= 1'b0;
            framesQ   <= '0;
        end else begin
            if (loadFrame) packetQ <= frameD;
            // Set wins over clear when both happen in one cycle.
            if (bus.in_valid && full) overflowQ <= 1'b1;
            else if (clr_overflow)    overflowQ <= 1'b0;
            if (frameDone) framesQ <= framesQ + 1'b1;
        end
    end

    assign bus.in_ready    = !full;
    assign bus.uart_packet = packetQ;
    assign fifo_level      = countQ;
    assign overflow        = overflowQ;
    assign frames_sent     = framesQ;

endmodule

// File: tb/tb_uart_frame_queue.sv
module tb_uart_frame_queue;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned FRAME_W = 11;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned CNT_W   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic parity_odd = 1'b0;
    logic clr_overflow = 1'b0;
    logic [$clog2(DEPTH):0] fifo_level;
    logic overflow;
    logic [CNT_W-1:0] frames_sent;

    uart_frame_queue_if #(.DATA_W(DATA_W), .FRAME_W(FRAME_W)) bus ();

    uart_frame_queue #(
        .DATA_W(DATA_W), .PARITY_EN(1), .STOP_BITS(1), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .parity_odd(parity_odd),
        .clr_overflow(clr_overflow),
        .fifo_level(fifo_level),
        .overflow(overflow),
        .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive/sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] frameOf(input logic [7:0] d, input logic odd);
        int  ones = 0;
        logic p;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        p = (ones % 2 == 1) ^ odd;
        return {1'b1, p, d, 1'b0};
    endfunction

    task automatic pushOne(input logic [7:0] d);
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic pulseDone();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  data;
        logic        odd;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs [7];
    int   expFrames;

    // Reference model state for the random phase
    logic [7:0]  mq [$];
    bit          mInFlight;
    logic [10:0] mPkt;
    bit          mOvf;
    int          mFrames;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 11'h54A};
        vecs[1] = '{8'hA5, 1'b1, 11'h74A};
        vecs[2] = '{8'h00, 1'b1, 11'h600};
        vecs[3] = '{8'hFF, 1'b1, 11'h7FE};
        vecs[4] = '{8'hFF, 1'b0, 11'h5FE};
        vecs[5] = '{8'h00, 1'b0, 11'h400};
        vecs[6] = '{8'h01, 1'b0, 11'h602};

        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus.tx_done  = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_tx_start", 32'(bus.tx_start), 32'd0);
        check("rst_packet", 32'(bus.uart_packet), 32'h7FF);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_frames", 32'(frames_sent), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // tx_done while idle is ignored
        pulseDone();
        check("idle_done_frames", 32'(frames_sent), 32'd0);
        check("idle_done_tx_start", 32'(bus.tx_start), 32'd0);

        // Table-driven single frames
        expFrames = 0;
        for (int v = 0; v < 7; v++) begin
            parity_odd = vecs[v].odd;
            pushOne(vecs[v].data);
            check($sformatf("v%0d_latency", v), 32'(bus.tx_start), 32'd0);
            tick();
            check($sformatf("v%0d_tx_start", v), 32'(bus.tx_start), 32'd1);
            check($sformatf("v%0d_packet", v), 32'(bus.uart_packet), 32'(vecs[v].exp));
            if (v == 0) begin
                for (int c = 0; c < 10; c++) begin
                    tick();
                    check("hold_tx_start", 32'(bus.tx_start), 32'd1);
                    check("hold_packet", 32'(bus.uart_packet), 32'h54A);
                end
            end
            pulseDone();
            expFrames++;
            check($sformatf("v%0d_done_tx_start", v), 32'(bus.tx_start), 32'd0);
            check($sformatf("v%0d_frames", v), 32'(frames_sent), 32'(expFrames % 16));
            check($sformatf("v%0d_packet_kept", v), 32'(bus.uart_packet), 32'(vecs[v].exp));
        end

        // Overflow: six consecutive pushes, five accepted
        parity_odd   = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.in_data = 8'h10 + 8'(i);
            tick();
        end
        bus.in_valid = 1'b0;
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_level", 32'(fifo_level), 32'd4);
        check("ovf_in_ready", 32'(bus.in_ready), 32'd0);
        check("ovf_in_flight", 32'(bus.uart_packet), 32'(frameOf(8'h10, 1'b0)));
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Drain in push order, one idle cycle between frames
        for (int k = 0; k < 5; k++) begin
            check($sformatf("drain%0d_tx_start", k), 32'(bus.tx_start), 32'd1);
            check($sformatf("drain%0d_packet", k), 32'(bus.uart_packet),
                  32'(frameOf(8'h10 + 8'(k), 1'b0)));
            pulseDone();
            expFrames++;
            check($sformatf("drain%0d_gap", k), 32'(bus.tx_start), 32'd0);
            tick();
        end
        check("drain_frames_wrap", 32'(frames_sent), 32'(expFrames % 16));
        check("drain_level", 32'(fifo_level), 32'd0);

        // Reset mid-SEND with three queued
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_data = 8'h30 + 8'(i);
            tick();
        end
        bus.in_valid = 1'b0;
        check("abort_level_before", 32'(fifo_level), 32'd3);
        check("abort_tx_start_before", 32'(bus.tx_start), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("abort_tx_start", 32'(bus.tx_start), 32'd0);
        check("abort_level", 32'(fifo_level), 32'd0);
        check("abort_packet", 32'(bus.uart_packet), 32'h7FF);
        tick();
        rst_n = 1'b1;
        parity_odd = 1'b0;
        pushOne(8'hA5);
        tick();
        check("post_rst_packet", 32'(bus.uart_packet), 32'h54A);
        check("post_rst_frames", 32'(frames_sent), 32'd0);

        // Randomized phase against a queue-based model
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        mq.delete();
        mInFlight = 0;
        mPkt      = 11'h7FF;
        mOvf      = 0;
        mFrames   = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [7:0] d;
            bit         iv, td, clr, odd, full;
            d   = 8'($urandom);
            iv  = ($urandom_range(0, 1) == 1);
            td  = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 7) == 0);
            odd = ($urandom_range(0, 1) == 1);
            bus.in_data  = d;
            bus.in_valid = iv;
            bus.tx_done  = td;
            clr_overflow = clr;
            parity_odd   = odd;
            tick();
            full = (mq.size() == DEPTH);
            if (iv && full) mOvf = 1;
            else if (clr)   mOvf = 0;
            if (mInFlight) begin
                if (td) begin
                    mInFlight = 0;
                    mFrames++;
                end
            end else if (mq.size() > 0) begin
                mPkt      = frameOf(mq.pop_front(), odd);
                mInFlight = 1;
            end
            if (iv && !full) mq.push_back(d);
            check("rnd_tx_start", 32'(bus.tx_start), 32'(mInFlight));
            check("rnd_packet", 32'(bus.uart_packet), 32'(mPkt));
            check("rnd_level", 32'(fifo_level), 32'(mq.size()));
            check("rnd_in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
            check("rnd_overflow", 32'(overflow), 32'(mOvf));
            check("rnd_frames", 32'(frames_sent), 32'(mFrames % 16));
        end
        bus.in_valid = 1'b0;
        bus.tx_done  = 1'b0;
        clr_overflow = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
